bias_act_quant: RTL and testbench



---
 rtl/bias_act_quant_if.sv | 36 +++
 rtl/bias_act_quant.sv | 203 ++++++++++++++++++++
 tb/tb_bias_act_quant.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_act_quant_if.sv
// ----------------------------------------------------------------------------
// bias_act_quant_if
//   Groups the request/result signals of bias_act_quant.
//   Clock and reset are not part of the bundle; they stay plain module ports.
//
//   start       master -> slave   request, sampled only while the stage is idle
//   in_vector   master -> slave   ROWS signed ACC_WIDTH accumulators, elem 0 in MSBs
//   bias        master -> slave   ROWS signed ACC_WIDTH biases, elem 0 in MSBs
//   out_vector  slave -> master   ROWS signed OUT_WIDTH results, elem 0 in MSBs
//   done        slave -> master   one-cycle pulse: out_vector/sat_flag just updated
//   busy        slave -> master   high while a vector is being processed
//   sat_flag    slave -> master   some element of the last run was clamped
// ----------------------------------------------------------------------------
interface bias_act_quant_if #(
   parameter int unsigned ROWS      = 6,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned OUT_WIDTH = 8
);
   logic                        start;
   logic [ROWS*ACC_WIDTH-1:0]   in_vector;
   logic [ROWS*ACC_WIDTH-1:0]   bias;
   logic [ROWS*OUT_WIDTH-1:0]   out_vector;
   logic                        done;
   logic                        busy;
   logic                        sat_flag;

   modport master (
      output start, in_vector, bias,
      input  out_vector, done, busy, sat_flag
   );

   modport slave (
      input  start, in_vector, bias,
      output out_vector, done, busy, sat_flag
   );
endinterface

// File: rtl/bias_act_quant.sv
// ----------------------------------------------------------------------------
// bias_act_quant
//   Post-processing stage behind the matrix-vector multiplier. Captures one
//   vector of signed accumulators plus a bias vector, then per element (one
//   per clock): add bias, activate, arithmetic shift right by SHIFT, saturate
//   to OUT_WIDTH. The complete quantised vector is published atomically
//   together with a one-cycle done pulse.
//
//   Ports
//     clk     rising-edge clock
//     reset   synchronous, active-high
//     bus     bias_act_quant_if.slave (start, in_vector, bias, out_vector,
//             done, busy, sat_flag)
//
//   Build option
//     LEAKY_RELU_EN  when defined, a negative sum becomes sum >>> 3 instead
//                    of 0, so negative outputs are possible. Undefined: plain
//                    ReLU, all outputs >= 0.
//
//   Timing: start sampled in IDLE at edge E0; elements are processed on
//   E1..E<ROWS>; done is high in the cycle following E<ROWS>. One vector
//   every ROWS+1 cycles when start is held high.
// ----------------------------------------------------------------------------
module bias_act_quant #(
   parameter int unsigned ROWS      = 6,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned OUT_WIDTH = 8,
   parameter int unsigned SHIFT     = 4
) (
   input logic            clk,
   input logic            reset,
   bias_act_quant_if.slave bus
);

   localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   // Sum width: one guard bit so in + bias never overflows.
   localparam int unsigned SW    = ACC_WIDTH + 1;

   localparam logic signed [SW-1:0] SAT_MAX = SW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {
      ST_IDLE,
      ST_PROCESS
   } state_t;

   state_t                      state_q;
   state_t                      state_d;

   // Latched operands: the bus inputs may change freely after the start edge.
   logic [ROWS*ACC_WIDTH-1:0]   in_buf_q;
   logic [ROWS*ACC_WIDTH-1:0]   bias_buf_q;

   // Working buffer filled one element per cycle, published at the end.
   logic [ROWS*OUT_WIDTH-1:0]   work_q;
   logic [ROWS*OUT_WIDTH-1:0]   work_d;

   logic [IDX_W-1:0]            idx_q;
   logic                        sat_acc_q;

   logic [ROWS*OUT_WIDTH-1:0]   out_vector_q;
   logic                        done_q;
   logic                        sat_flag_q;

   // Per-element datapath
   logic signed [ACC_WIDTH-1:0] cur_in;
   logic signed [ACC_WIDTH-1:0] cur_bias;
   logic signed [SW-1:0]        sum;
   logic signed [SW-1:0]        act;
   logic signed [SW-1:0]        shifted;
   logic [OUT_WIDTH-1:0]        q_elem;
   logic                        clamped;
   logic                        last_elem;

   assign last_elem = (idx_q == IDX_W'(ROWS - 1));

   // ------------------------------------------------------------------------
   // Operand selection for the current element index
   // ------------------------------------------------------------------------
   always_comb begin
      cur_in   = '0;
      cur_bias = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_in   = in_buf_q  [(ROWS - 1 - i) * ACC_WIDTH +: ACC_WIDTH];
            cur_bias = bias_buf_q[(ROWS - 1 - i) * ACC_WIDTH +: ACC_WIDTH];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Bias, activation, shift, saturation
   // ------------------------------------------------------------------------
   always_comb begin
      sum = {cur_in[ACC_WIDTH-1], cur_in} + {cur_bias[ACC_WIDTH-1], cur_bias};

`ifdef LEAKY_RELU_EN
      // Leaky slope of 1/8, rounding toward minus infinity.
      act = sum[SW-1] ? (sum >>> 3) : sum;
`else
      act = sum[SW-1] ? '0 : sum;
`endif

      shifted = act >>> SHIFT;

      clamped = 1'b0;
      if (shifted > SAT_MAX) begin
         q_elem  = SAT_MAX[OUT_WIDTH-1:0];
         clamped = 1'b1;
      end else if (shifted < SAT_MIN) begin
         q_elem  = SAT_MIN[OUT_WIDTH-1:0];
         clamped = 1'b1;
      end else begin
         q_elem  = shifted[OUT_WIDTH-1:0];
      end
   end

   // Working buffer with the current element merged in; this is also what
   // gets published on the last element, so that element is not lost.
   always_comb begin
      work_d = work_q;
      for (int unsigned i = 0; i < ROWS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            work_d[(ROWS - 1 - i) * OUT_WIDTH +: OUT_WIDTH] = q_elem;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_PROCESS;
            end
         end
         ST_PROCESS: begin
            if (last_elem) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Capture, element processing and result publication
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         in_buf_q     <= '0;
         bias_buf_q   <= '0;
         work_q       <= '0;
         idx_q        <= '0;
         sat_acc_q    <= 1'b0;
         out_vector_q <= '0;
         done_q       <= 1'b0;
         sat_flag_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  in_buf_q   <= bus.in_vector;
                  bias_buf_q <= bus.bias;
                  idx_q      <= '0;
                  sat_acc_q  <= 1'b0;
               end
            end
            ST_PROCESS: begin
               work_q <= work_d;
               if (last_elem) begin
                  out_vector_q <= work_d;
                  sat_flag_q   <= sat_acc_q | clamped;
                  done_q       <= 1'b1;
                  idx_q        <= '0;
               end else begin
                  idx_q     <= idx_q + IDX_W'(1);
                  sat_acc_q <= sat_acc_q | clamped;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.out_vector = out_vector_q;
   assign bus.done       = done_q;
   assign bus.busy       = (state_q == ST_PROCESS);
   assign bus.sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_bias_act_quant.sv
// ----------------------------------------------------------------------------
// tb_bias_act_quant
//   Directed bench for bias_act_quant (ROWS=6, ACC_WIDTH=16, OUT_WIDTH=8,
//   SHIFT=4). Expected results are queued when a run is launched and popped
//   when done pulses. Define LEAKY_RELU_EN for both bench and RTL to cover
//   the leaky activation build.
// ----------------------------------------------------------------------------
module tb_bias_act_quant;

   localparam int ROWS  = 6;
   localparam int AW    = 16;
   localparam int OW    = 8;
   localparam int SHIFT = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bias_act_quant_if #(.ROWS(ROWS), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) bus ();

   bias_act_quant #(
      .ROWS      (ROWS),
      .ACC_WIDTH (AW),
      .OUT_WIDTH (OW),
      .SHIFT     (SHIFT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [ROWS*OW-1:0] out;
      logic               sat;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ROWS*AW-1:0] pack_acc(input int v[ROWS]);
      logic [ROWS*AW-1:0] p;
      logic [31:0]        t;
      p = '0;
      for (int i = 0; i < ROWS; i++) begin
         t = v[i];
         p[(ROWS-1-i)*AW +: AW] = t[AW-1:0];
      end
      return p;
   endfunction

   function automatic logic [ROWS*OW-1:0] pack_out(input int v[ROWS]);
      logic [ROWS*OW-1:0] p;
      logic [31:0]        t;
      p = '0;
      for (int i = 0; i < ROWS; i++) begin
         t = v[i];
         p[(ROWS-1-i)*OW +: OW] = t[OW-1:0];
      end
      return p;
   endfunction

   // Reference arithmetic on plain integers (floor division written out).
   function automatic exp_t model(input int vin[ROWS], input int vb[ROWS]);
      exp_t e;
      int   s, a, q;
      int   o[ROWS];
      e.sat = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         s = vin[i] + vb[i];
         if (s < 0) begin
`ifdef LEAKY_RELU_EN
            a = (s - 7) / 8;
`else
            a = 0;
`endif
         end else begin
            a = s;
         end
         q = (a >= 0) ? a / 16 : (a - 15) / 16;
         if (q > 127) begin
            q = 127;
            e.sat = 1'b1;
         end else if (q < -128) begin
            q = -128;
            e.sat = 1'b1;
         end
         o[i] = q;
      end
      e.out = pack_out(o);
      return e;
   endfunction

   function automatic exp_t mk_exp(input int o[ROWS], input logic sat);
      exp_t e;
      e.out = pack_out(o);
      e.sat = sat;
      return e;
   endfunction

   task automatic pulse_start(input int vin[ROWS], input int vb[ROWS]);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.in_vector = pack_acc(vin);
      bus.bias      = pack_acc(vb);
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget, output int lat, output int busy_cnt);
      exp_t e;
      logic seen;
      seen     = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      while (!seen && lat < budget) begin
         @(negedge clk);
         lat++;
         if (bus.done) seen = 1'b1;
         else if (bus.busy) busy_cnt++;
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            last_exp = e;
            check({tag, "_out"}, bus.out_vector, e.out);
            check({tag, "_sat"}, bus.sat_flag, e.sat);
            check({tag, "_busy_at_done"}, bus.busy, 0);
         end
      end
   endtask

   task automatic expect_quiet(input string tag, input int n);
      logic saw;
      saw = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw = 1'b1;
      end
      check({tag, "_quiet"}, saw, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int vin[ROWS];
      int vb[ROWS];
      int vz[ROWS];
      int o[ROWS];
      int lat, bc;

      vz = '{0, 0, 0, 0, 0, 0};

      // ---------------- reset, with start pulsing during reset -------------
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.in_vector = '0;
      bus.bias      = '0;
      @(negedge clk);
      vin = '{1000, 1000, 1000, 1000, 1000, 1000};
      bus.start     = 1'b1;
      bus.in_vector = pack_acc(vin);
      @(negedge clk);
      @(negedge clk);
      check("rst_out",  bus.out_vector, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_sat",  bus.sat_flag, 0);
      bus.start = 1'b0;
      reset     = 1'b0;
      expect_quiet("post_rst", 8);
      check("post_rst_out", bus.out_vector, 0);

      // ---------------- basic run ------------------------------------------
      vin = '{100, -50, 0, 2047, 16, -1};
`ifdef LEAKY_RELU_EN
      o = '{6, -1, 0, 127, 1, -1};
`else
      o = '{6, 0, 0, 127, 1, 0};
`endif
      sb.push_back(mk_exp(o, 1'b0));
      pulse_start(vin, vz);
      check("basic_busy_first", bus.busy, 1);
      wait_done("basic", 20, lat, bc);
      check("basic_latency", lat, 6);
      check("basic_busy_cycles", bc + 1, 6);
      @(negedge clk);
      check("basic_done_width", bus.done, 0);
      expect_quiet("basic_after", 5);
      check("basic_hold", bus.out_vector, last_exp.out);

      // ---------------- saturation -----------------------------------------
      vin = '{32767, 0, 0, 0, 0, 0};
      vb  = '{32767, 0, 0, 0, 0, 0};
`ifdef LEAKY_RELU_EN
      vin[1] = -32768;
      vb[1]  = -32768;
      o = '{127, -128, 0, 0, 0, 0};
`else
      o = '{127, 0, 0, 0, 0, 0};
`endif
      sb.push_back(mk_exp(o, 1'b1));
      pulse_start(vin, vb);
      wait_done("sat", 20, lat, bc);

      // ---------------- start held high: one result every 7 cycles ---------
      vin = '{32, -32, 320, 1000, -4000, 5};
      vb  = '{0, 16, -100, 100, 0, 11};
      @(negedge clk);
      bus.start     = 1'b1;
      bus.in_vector = pack_acc(vin);
      bus.bias      = pack_acc(vb);
      repeat (3) sb.push_back(model(vin, vb));
      wait_done("held1", 20, lat, bc);
      check("held1_period", lat, 7);
      wait_done("held2", 20, lat, bc);
      check("held2_period", lat, 7);
      wait_done("held3", 20, lat, bc);
      check("held3_period", lat, 7);
      bus.start = 1'b0;
      expect_quiet("held_after", 10);

      // ---------------- mid-run start and input change ignored -------------
      vin = '{500, 600, -700, 800, 900, 4000};
      vb  = '{-20, 30, 1000, -5000, 0, 0};
      sb.push_back(model(vin, vb));
      pulse_start(vin, vb);
      @(negedge clk);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.in_vector = pack_acc(vz);
      @(negedge clk);
      bus.start     = 1'b0;
      bus.bias      = {ROWS{16'h7FFF}};
      wait_done("midrun", 20, lat, bc);
      check("midrun_latency", lat, 3);
      expect_quiet("midrun_after", 10);

      // ---------------- reset on the 3rd PROCESS edge ----------------------
      check("pre_abort_out_nonzero", bus.out_vector != 0, 1);
      vin = '{1600, 1600, 1600, 1600, 1600, 1600};
      pulse_start(vin, vz);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_out",  bus.out_vector, 0);
      check("abort_sat",  bus.sat_flag, 0);
      reset = 1'b0;
      expect_quiet("abort_after", 10);
      sb.push_back(model(vin, vz));
      pulse_start(vin, vz);
      wait_done("after_abort", 20, lat, bc);
      check("after_abort_latency", lat, 6);

      // ---------------- activation mode ------------------------------------
      vin = '{-160, 0, 0, 0, 0, 0};
`ifdef LEAKY_RELU_EN
      o = '{-2, 0, 0, 0, 0, 0};
`else
      o = '{0, 0, 0, 0, 0, 0};
`endif
      sb.push_back(mk_exp(o, 1'b0));
      pulse_start(vin, vz);
      wait_done("act", 20, lat, bc);

      // ---------------- random vectors against the integer model -----------
      repeat (4) begin
         for (int i = 0; i < ROWS; i++) begin
            vin[i] = int'($urandom_range(0, 65535)) - 32768;
            vb[i]  = int'($urandom_range(0, 65535)) - 32768;
         end
         sb.push_back(model(vin, vb));
         pulse_start(vin, vb);
         wait_done("rand", 20, lat, bc);
      end

      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
